// File: rtl/rf_2p_arbiter_if.sv
// Client-side and RF-side bus of the 2-port register-file arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives clients and the RF.
interface rf_2p_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DWD  = 16,
    parameter int AWD  = 4,
    parameter int SIZE = 1
);
    logic [NREQ-1:0]                      i_rd_valid;
    logic [NREQ-1:0]                      o_rd_ready;
    logic [NREQ-1:0][AWD-1:0]             i_rd_addr;
    logic [NREQ-1:0]                      o_rd_rvalid;
    logic [SIZE-1:0][DWD-1:0]             o_rd_rdata;

    logic [NREQ-1:0]                      i_wr_valid;
    logic [NREQ-1:0]                      o_wr_ready;
    logic [NREQ-1:0][AWD-1:0]             i_wr_addr;
    logic [NREQ-1:0][SIZE-1:0][DWD-1:0]   i_wr_data;

    logic                                 o_rf_read;
    logic [AWD-1:0]                       o_rf_raddr;
    logic [SIZE-1:0][DWD-1:0]             i_rf_rdata;
    logic                                 o_rf_write;
    logic [AWD-1:0]                       o_rf_waddr;
    logic [SIZE-1:0][DWD-1:0]             o_rf_wdata;
    logic                                 o_addr_err;

    modport slave (
        input  i_rd_valid, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_rf_rdata,
        output o_rd_ready, o_rd_rvalid, o_rd_rdata, o_wr_ready,
               o_rf_read, o_rf_raddr, o_rf_write, o_rf_waddr, o_rf_wdata, o_addr_err
    );

    modport master (
        output i_rd_valid, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_rf_rdata,
        input  o_rd_ready, o_rd_rvalid, o_rd_rdata, o_wr_ready,
               o_rf_read, o_rf_raddr, o_rf_write, o_rf_waddr, o_rf_wdata, o_addr_err
    );
endinterface

// File: rtl/rf_2p_arbiter.sv
// Round-robin arbiter sharing one 1R+1W register file between NREQ read and NREQ write clients.
// Macro RF_2P_ARB_FWD_EN: a same-address read is served from the colliding write instead of stalling.
module rf_2p_arbiter #(
    parameter int NREQ   = 4,
    parameter int WORDWD = 12,
    parameter int DWD    = 16,
    parameter int AWD    = $clog2(WORDWD),
    parameter int SIZE   = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    rf_2p_arbiter_if.slave bus
);
    localparam int PWD = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AWD:0] WORDWD_L = (AWD + 1)'(WORDWD);

    typedef logic [SIZE-1:0][DWD-1:0] word_t;

    logic [PWD-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PWD-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PWD:0]    rd_pick_s, wr_pick_s;
    logic            rd_cand_s, wr_cand_s;
    logic [PWD-1:0]  rd_win_s, wr_win_s;
    logic [AWD-1:0]  rd_addr_s, wr_addr_s;
    word_t           wr_data_s;
    logic            rd_oor_s, wr_oor_s;
    logic            collide_s, rd_grant_s;
    logic            rf_read_s, rf_write_s;
    logic [NREQ-1:0] rd_ready_s, wr_ready_s;
    word_t           rd_rdata_s;

    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic            rerr_q, rerr_d;
    logic            fwd_q, fwd_d;
    logic            addr_err_q, addr_err_d;
    logic [AWD-1:0]  raddr_q, raddr_d;
    logic [AWD-1:0]  waddr_q, waddr_d;
    word_t           wdata_q, wdata_d;

    // Returns {found, index} of the first valid client at or after ptr, wrapping around.
    function automatic logic [PWD:0] rr_pick(input logic [NREQ-1:0] valid, input logic [PWD-1:0] ptr);
        logic [PWD:0] res;
        int unsigned  idx;
        res = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (32'(ptr) + 32'(i)) % 32'(NREQ);
            if (valid[idx[PWD-1:0]]) begin
                res = {1'b1, idx[PWD-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [PWD-1:0] ptr_after(input logic [PWD-1:0] win);
        return PWD'((32'(win) + 32'd1) % 32'(NREQ));
    endfunction

    // Candidate selection, collision detection and grant generation for both ports.
    always_comb begin
        rd_pick_s  = rr_pick(bus.i_rd_valid, rd_ptr_q);
        wr_pick_s  = rr_pick(bus.i_wr_valid, wr_ptr_q);
        rd_cand_s  = rd_pick_s[PWD];
        rd_win_s   = rd_pick_s[PWD-1:0];
        wr_cand_s  = wr_pick_s[PWD];
        wr_win_s   = wr_pick_s[PWD-1:0];
        rd_addr_s  = bus.i_rd_addr[rd_win_s];
        wr_addr_s  = bus.i_wr_addr[wr_win_s];
        wr_data_s  = bus.i_wr_data[wr_win_s];
        rd_oor_s   = ({1'b0, rd_addr_s} >= WORDWD_L);
        wr_oor_s   = ({1'b0, wr_addr_s} >= WORDWD_L);
        collide_s  = rd_cand_s & wr_cand_s & (rd_addr_s == wr_addr_s);
`ifdef RF_2P_ARB_FWD_EN
        rd_grant_s = rd_cand_s;
`else
        rd_grant_s = rd_cand_s & ~collide_s;
`endif
        rf_read_s  = rd_grant_s & ~rd_oor_s & ~collide_s & ~i_rst;
        rf_write_s = wr_cand_s & ~wr_oor_s & ~i_rst;
        rd_ready_s = '0;
        wr_ready_s = '0;
        if (rd_grant_s) begin
            rd_ready_s[rd_win_s] = 1'b1;
        end else begin
            rd_ready_s = '0;
        end
        if (wr_cand_s) begin
            wr_ready_s[wr_win_s] = 1'b1;
        end else begin
            wr_ready_s = '0;
        end
    end

    // Next state: pointers advance past the winner; RF pins only change on a real access.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        rvalid_d   = rd_ready_s;
        rerr_d     = rd_grant_s & rd_oor_s;
        fwd_d      = rd_grant_s & collide_s;
        addr_err_d = addr_err_q | (rd_grant_s & rd_oor_s) | (wr_cand_s & wr_oor_s);
        if (rd_grant_s) begin
            rd_ptr_d = ptr_after(rd_win_s);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (wr_cand_s) begin
            wr_ptr_d = ptr_after(wr_win_s);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rf_read_s) begin
            raddr_d = rd_addr_s;
        end else begin
            raddr_d = raddr_q;
        end
        if (rf_write_s) begin
            waddr_d = wr_addr_s;
            wdata_d = wr_data_s;
        end else begin
            waddr_d = waddr_q;
            wdata_d = wdata_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            rvalid_q   <= '0;
            rerr_q     <= 1'b0;
            fwd_q      <= 1'b0;
            addr_err_q <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
            fwd_q      <= fwd_d;
            addr_err_q <= addr_err_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Read response: wdata_q still holds the forwarded write one cycle after a collision.
    always_comb begin
        rd_rdata_s = '0;
        if ((rvalid_q != '0) && !rerr_q) begin
            rd_rdata_s = fwd_q ? wdata_q : bus.i_rf_rdata;
        end else begin
            rd_rdata_s = '0;
        end
    end

    assign bus.o_rd_ready  = rd_ready_s;
    assign bus.o_wr_ready  = wr_ready_s;
    assign bus.o_rd_rvalid = rvalid_q;
    assign bus.o_rd_rdata  = rd_rdata_s;
    assign bus.o_rf_read   = rf_read_s;
    assign bus.o_rf_raddr  = raddr_d;
    assign bus.o_rf_write  = rf_write_s;
    assign bus.o_rf_waddr  = waddr_d;
    assign bus.o_rf_wdata  = wdata_d;
    assign bus.o_addr_err  = addr_err_q;
endmodule

// File: tb/tb_rf_2p_arbiter.sv
// Self-checking bench for rf_2p_arbiter: directed scenarios plus random traffic against a reference model.
`timescale 1ns/1ps
module tb_rf_2p_arbiter;
    localparam int NREQ   = 4;
    localparam int WORDWD = 12;
    localparam int DWD    = 16;
    localparam int AWD    = $clog2(WORDWD);
    localparam int SIZE   = 1;
    localparam int NCYC   = 1500;
`ifdef RF_2P_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [DWD-1:0] rf_mem [0:(1<<AWD)-1];

    rf_2p_arbiter_if #(.NREQ(NREQ), .DWD(DWD), .AWD(AWD), .SIZE(SIZE)) bus ();

    rf_2p_arbiter #(.NREQ(NREQ), .WORDWD(WORDWD), .DWD(DWD), .AWD(AWD), .SIZE(SIZE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Advances one clock and plays the RF macro: 1-cycle read, X on same-address read/write.
    task automatic tick();
        logic           rd, wr;
        logic [AWD-1:0] ra, wa;
        logic [DWD-1:0] wd, q;
        rd = bus.o_rf_read;
        wr = bus.o_rf_write;
        ra = bus.o_rf_raddr;
        wa = bus.o_rf_waddr;
        wd = bus.o_rf_wdata[0];
        q  = 'x;
        if (rd === 1'b1) begin
            if (wr === 1'b1 && wa == ra) q = 'x;
            else q = rf_mem[ra];
        end
        @(posedge clk);
        #1;
        if (wr === 1'b1) rf_mem[wa] = wd;
        bus.i_rf_rdata[0] = q;
    endtask

    task automatic idle();
        bus.i_rd_valid = '0;
        bus.i_wr_valid = '0;
    endtask

    task automatic test_reset();
        bus.i_rd_valid = '1;
        bus.i_wr_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            bus.i_rd_addr[i]    = AWD'(i);
            bus.i_wr_addr[i]    = AWD'(i + 4);
            bus.i_wr_data[i][0] = DWD'(16'h1000 + i);
        end
        rst = 1'b1;
        tick();
        tick();
        total += 5;
        if (bus.o_rf_read !== 1'b0) begin bad++; $display("FAIL reset_rf_read got=%b want=0", bus.o_rf_read); end
        if (bus.o_rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write got=%b want=0", bus.o_rf_write); end
        if (bus.o_rd_rvalid !== 4'b0000) begin bad++; $display("FAIL reset_rvalid got=%b want=0000", bus.o_rd_rvalid); end
        if (bus.o_rd_rdata[0] !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", bus.o_rd_rdata[0]); end
        if (bus.o_addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got=%b want=0", bus.o_addr_err); end
        idle();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rr_reads();
        logic [NREQ-1:0] exp;
        for (int i = 0; i < NREQ; i++) bus.i_rd_addr[i] = AWD'(i);
        bus.i_rd_valid = '1;
        for (int c = 0; c <= 2 * NREQ; c++) begin
            if (c == 2 * NREQ) bus.i_rd_valid = '0;
            #1;
            if (c < 2 * NREQ) begin
                exp = NREQ'(1 << (c % NREQ));
                total += 2;
                if (bus.o_rd_ready !== exp) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, bus.o_rd_ready, exp); end
                if (bus.o_rf_read !== 1'b1) begin bad++; $display("FAIL rr_rf_read c=%0d got=%b want=1", c, bus.o_rf_read); end
            end
            if (c > 0) begin
                exp = NREQ'(1 << ((c - 1) % NREQ));
                total++;
                if (bus.o_rd_rvalid !== exp) begin bad++; $display("FAIL rr_rvalid c=%0d got=%b want=%b", c, bus.o_rd_rvalid, exp); end
            end
            tick();
        end
    endtask

    task automatic test_basic_rw();
        bus.i_wr_valid      = 4'b0001;
        bus.i_wr_addr[0]    = 4'd5;
        bus.i_wr_data[0][0] = 16'hABCD;
        #1;
        total += 4;
        if (bus.o_wr_ready !== 4'b0001) begin bad++; $display("FAIL wr_ready got=%b want=0001", bus.o_wr_ready); end
        if (bus.o_rf_write !== 1'b1) begin bad++; $display("FAIL wr_rf_write got=%b want=1", bus.o_rf_write); end
        if (bus.o_rf_waddr !== 4'd5) begin bad++; $display("FAIL wr_waddr got=%0d want=5", bus.o_rf_waddr); end
        if (bus.o_rf_wdata[0] !== 16'hABCD) begin bad++; $display("FAIL wr_wdata got=%h want=abcd", bus.o_rf_wdata[0]); end
        tick();
        idle();
        bus.i_rd_valid   = 4'b0100;
        bus.i_rd_addr[2] = 4'd5;
        #1;
        total += 3;
        if (bus.o_rd_ready !== 4'b0100) begin bad++; $display("FAIL rd_ready got=%b want=0100", bus.o_rd_ready); end
        if (bus.o_rf_read !== 1'b1) begin bad++; $display("FAIL rd_rf_read got=%b want=1", bus.o_rf_read); end
        if (bus.o_rf_raddr !== 4'd5) begin bad++; $display("FAIL rd_raddr got=%0d want=5", bus.o_rf_raddr); end
        tick();
        idle();
        #1;
        total += 6;
        if (bus.o_rd_rvalid !== 4'b0100) begin bad++; $display("FAIL rd_rvalid got=%b want=0100", bus.o_rd_rvalid); end
        if (bus.o_rd_rdata[0] !== 16'hABCD) begin bad++; $display("FAIL rd_rdata got=%h want=abcd", bus.o_rd_rdata[0]); end
        if (bus.o_rf_read !== 1'b0) begin bad++; $display("FAIL idle_rf_read got=%b want=0", bus.o_rf_read); end
        if (bus.o_rf_raddr !== 4'd5) begin bad++; $display("FAIL idle_raddr_hold got=%0d want=5", bus.o_rf_raddr); end
        if (bus.o_rf_waddr !== 4'd5) begin bad++; $display("FAIL idle_waddr_hold got=%0d want=5", bus.o_rf_waddr); end
        if (bus.o_rf_wdata[0] !== 16'hABCD) begin bad++; $display("FAIL idle_wdata_hold got=%h want=abcd", bus.o_rf_wdata[0]); end
        tick();
    endtask

    task automatic test_collision();
        bus.i_wr_valid      = 4'b0001;
        bus.i_wr_addr[0]    = 4'd3;
        bus.i_wr_data[0][0] = 16'h1234;
        bus.i_rd_valid      = 4'b0011;
        bus.i_rd_addr[0]    = 4'd3;
        bus.i_rd_addr[1]    = 4'd7;
        #1;
        total += 4;
        if (bus.o_wr_ready !== 4'b0001) begin bad++; $display("FAIL coll_wr_ready got=%b want=0001", bus.o_wr_ready); end
        if (bus.o_rf_write !== 1'b1) begin bad++; $display("FAIL coll_rf_write got=%b want=1", bus.o_rf_write); end
        if (bus.o_rf_read !== 1'b0) begin bad++; $display("FAIL coll_rf_read got=%b want=0", bus.o_rf_read); end
        if (bus.o_rd_ready !== (FWD ? 4'b0001 : 4'b0000)) begin
            bad++; $display("FAIL coll_rd_ready got=%b want=%b", bus.o_rd_ready, (FWD ? 4'b0001 : 4'b0000));
        end
        tick();
        bus.i_wr_valid = '0;
`ifdef RF_2P_ARB_FWD_EN
        bus.i_rd_valid = 4'b0010;
        #1;
        total += 3;
        if (bus.o_rd_rvalid !== 4'b0001) begin bad++; $display("FAIL fwd_rvalid got=%b want=0001", bus.o_rd_rvalid); end
        if (bus.o_rd_rdata[0] !== 16'h1234) begin bad++; $display("FAIL fwd_rdata got=%h want=1234", bus.o_rd_rdata[0]); end
        if (bus.o_rd_ready !== 4'b0010) begin bad++; $display("FAIL fwd_next_grant got=%b want=0010", bus.o_rd_ready); end
        tick();
`else
        #1;
        total += 4;
        if (bus.o_rd_ready !== 4'b0001) begin bad++; $display("FAIL stall_retry_grant got=%b want=0001", bus.o_rd_ready); end
        if (bus.o_rf_read !== 1'b1) begin bad++; $display("FAIL stall_retry_read got=%b want=1", bus.o_rf_read); end
        if (bus.o_rf_raddr !== 4'd3) begin bad++; $display("FAIL stall_retry_raddr got=%0d want=3", bus.o_rf_raddr); end
        if (bus.o_rd_rvalid !== 4'b0000) begin bad++; $display("FAIL stall_no_rvalid got=%b want=0000", bus.o_rd_rvalid); end
        tick();
        bus.i_rd_valid = 4'b0010;
        #1;
        total += 3;
        if (bus.o_rd_rvalid !== 4'b0001) begin bad++; $display("FAIL stall_rvalid got=%b want=0001", bus.o_rd_rvalid); end
        if (bus.o_rd_rdata[0] !== 16'h1234) begin bad++; $display("FAIL stall_rdata got=%h want=1234", bus.o_rd_rdata[0]); end
        if (bus.o_rd_ready !== 4'b0010) begin bad++; $display("FAIL stall_next_grant got=%b want=0010", bus.o_rd_ready); end
        tick();
`endif
        idle();
        #1;
        total++;
        if (bus.o_rd_rvalid !== 4'b0010) begin bad++; $display("FAIL coll_last_rvalid got=%b want=0010", bus.o_rd_rvalid); end
        tick();
    endtask

    task automatic test_addr_err();
        bus.i_wr_valid      = 4'b0010;
        bus.i_wr_addr[1]    = 4'd12;
        bus.i_wr_data[1][0] = 16'h5555;
        #1;
        total += 4;
        if (bus.o_wr_ready !== 4'b0010) begin bad++; $display("FAIL oor_wr_ready got=%b want=0010", bus.o_wr_ready); end
        if (bus.o_rf_write !== 1'b0) begin bad++; $display("FAIL oor_rf_write got=%b want=0", bus.o_rf_write); end
        if (bus.o_rf_waddr !== 4'd3) begin bad++; $display("FAIL oor_waddr_hold got=%0d want=3", bus.o_rf_waddr); end
        if (bus.o_addr_err !== 1'b0) begin bad++; $display("FAIL oor_err_early got=%b want=0", bus.o_addr_err); end
        tick();
        idle();
        bus.i_rd_valid   = 4'b0010;
        bus.i_rd_addr[1] = 4'd13;
        #1;
        total += 3;
        if (bus.o_addr_err !== 1'b1) begin bad++; $display("FAIL oor_err_set got=%b want=1", bus.o_addr_err); end
        if (bus.o_rd_ready !== 4'b0010) begin bad++; $display("FAIL oor_rd_ready got=%b want=0010", bus.o_rd_ready); end
        if (bus.o_rf_read !== 1'b0) begin bad++; $display("FAIL oor_rf_read got=%b want=0", bus.o_rf_read); end
        tick();
        idle();
        #1;
        total += 2;
        if (bus.o_rd_rvalid !== 4'b0010) begin bad++; $display("FAIL oor_rvalid got=%b want=0010", bus.o_rd_rvalid); end
        if (bus.o_rd_rdata[0] !== 16'h0000) begin bad++; $display("FAIL oor_rdata got=%h want=0000", bus.o_rd_rdata[0]); end
        repeat (3) tick();
        total++;
        if (bus.o_addr_err !== 1'b1) begin bad++; $display("FAIL oor_err_sticky got=%b want=1", bus.o_addr_err); end
    endtask

    task automatic test_reset_mid();
        bus.i_rd_valid   = 4'b1000;
        bus.i_rd_addr[3] = 4'd2;
        rst = 1'b1;
        #1;
        total++;
        if (bus.o_rf_read !== 1'b0) begin bad++; $display("FAIL rstmid_rf_read got=%b want=0", bus.o_rf_read); end
        tick();
        rst = 1'b0;
        idle();
        #1;
        total += 2;
        if (bus.o_rd_rvalid !== 4'b0000) begin bad++; $display("FAIL rstmid_rvalid got=%b want=0000", bus.o_rd_rvalid); end
        if (bus.o_addr_err !== 1'b0) begin bad++; $display("FAIL rstmid_addr_err got=%b want=0", bus.o_addr_err); end
        tick();
        for (int i = 0; i < NREQ; i++) begin
            bus.i_rd_addr[i] = AWD'(i + 8);
            bus.i_wr_addr[i] = AWD'(i);
        end
        bus.i_rd_valid = '1;
        bus.i_wr_valid = '1;
        #1;
        total += 2;
        if (bus.o_rd_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_rd_ptr got=%b want=0001", bus.o_rd_ready); end
        if (bus.o_wr_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_wr_ptr got=%b want=0001", bus.o_wr_ready); end
        tick();
        idle();
        tick();
    endtask

    function automatic int pick_addr();
        if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 3));
        else return int'($urandom_range(0, 13));
    endfunction

    task automatic test_random();
        logic [DWD-1:0]  ref_mem [0:(1<<AWD)-1];
        bit              rvp [NREQ];
        bit              wvp [NREQ];
        int              ra [NREQ];
        int              wa [NREQ];
        logic [DWD-1:0]  wd [NREQ];
        int              rwait [NREQ];
        int              wwait [NREQ];
        int              rptr, wptr, rc, wc, last_ra, last_wa, idx;
        logic [DWD-1:0]  last_wd, exp_rd;
        logic [NREQ-1:0] exp_rv, exp_rready, exp_wready;
        bit              coll, rg, exp_read, exp_write, err;

        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < (1 << AWD); i++) ref_mem[i] = rf_mem[i];
        for (int i = 0; i < NREQ; i++) begin
            rvp[i] = 1'b0; wvp[i] = 1'b0; rwait[i] = 0; wwait[i] = 0;
            ra[i] = 0; wa[i] = 0; wd[i] = '0;
        end
        rptr = 0; wptr = 0; last_ra = 0; last_wa = 0; last_wd = '0;
        exp_rv = '0; exp_rd = '0; err = 1'b0;

        for (int c = 0; c < NCYC; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rvp[i] && $urandom_range(0, 1) == 1) begin rvp[i] = 1'b1; ra[i] = pick_addr(); end
                if (!wvp[i] && $urandom_range(0, 1) == 1) begin
                    wvp[i] = 1'b1; wa[i] = pick_addr(); wd[i] = DWD'($urandom);
                end
                bus.i_rd_valid[i]   = rvp[i];
                bus.i_rd_addr[i]    = AWD'(ra[i]);
                bus.i_wr_valid[i]   = wvp[i];
                bus.i_wr_addr[i]    = AWD'(wa[i]);
                bus.i_wr_data[i][0] = wd[i];
            end
            #1;
            rc = -1;
            wc = -1;
            for (int k = NREQ - 1; k >= 0; k--) begin
                idx = (rptr + k) % NREQ;
                if (rvp[idx]) rc = idx;
                idx = (wptr + k) % NREQ;
                if (wvp[idx]) wc = idx;
            end
            coll = 1'b0;
            if (rc >= 0 && wc >= 0) coll = (ra[rc] == wa[wc]);
            rg = (rc >= 0) && (FWD || !coll);
            exp_rready = rg ? NREQ'(1 << rc) : '0;
            exp_wready = (wc >= 0) ? NREQ'(1 << wc) : '0;
            exp_write = 1'b0;
            exp_read  = 1'b0;
            if (wc >= 0 && wa[wc] < WORDWD) begin exp_write = 1'b1; last_wa = wa[wc]; last_wd = wd[wc]; end
            if (rg && !coll && ra[rc] < WORDWD) begin exp_read = 1'b1; last_ra = ra[rc]; end

            total += 12;
            if (bus.o_rd_ready !== exp_rready) begin bad++; $display("FAIL rnd_rd_ready c=%0d got=%b want=%b", c, bus.o_rd_ready, exp_rready); end
            if (bus.o_wr_ready !== exp_wready) begin bad++; $display("FAIL rnd_wr_ready c=%0d got=%b want=%b", c, bus.o_wr_ready, exp_wready); end
            if (bus.o_rf_read !== exp_read) begin bad++; $display("FAIL rnd_rf_read c=%0d got=%b want=%b", c, bus.o_rf_read, exp_read); end
            if (bus.o_rf_write !== exp_write) begin bad++; $display("FAIL rnd_rf_write c=%0d got=%b want=%b", c, bus.o_rf_write, exp_write); end
            if (bus.o_rf_raddr !== AWD'(last_ra)) begin bad++; $display("FAIL rnd_raddr c=%0d got=%0d want=%0d", c, bus.o_rf_raddr, last_ra); end
            if (bus.o_rf_waddr !== AWD'(last_wa)) begin bad++; $display("FAIL rnd_waddr c=%0d got=%0d want=%0d", c, bus.o_rf_waddr, last_wa); end
            if (bus.o_rf_wdata[0] !== last_wd) begin bad++; $display("FAIL rnd_wdata c=%0d got=%h want=%h", c, bus.o_rf_wdata[0], last_wd); end
            if (bus.o_rd_rvalid !== exp_rv) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b want=%b", c, bus.o_rd_rvalid, exp_rv); end
            if (bus.o_rd_rdata[0] !== exp_rd) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, bus.o_rd_rdata[0], exp_rd); end
            if ($isunknown(bus.o_rd_rdata)) begin bad++; $display("FAIL rnd_rdata_x c=%0d got=%h want=known", c, bus.o_rd_rdata[0]); end
            if (bus.o_addr_err !== err) begin bad++; $display("FAIL rnd_addr_err c=%0d got=%b want=%b", c, bus.o_addr_err, err); end
            if (bus.o_rf_read === 1'b1 && bus.o_rf_write === 1'b1 && bus.o_rf_raddr == bus.o_rf_waddr) begin
                bad++; $display("FAIL rnd_rf_collision c=%0d got=addr %0d read+write want=no overlap", c, bus.o_rf_raddr);
            end

            exp_rv = exp_rready;
            exp_rd = '0;
            if (rg && ra[rc] < WORDWD) exp_rd = coll ? wd[wc] : ref_mem[ra[rc]];
            if (rg && ra[rc] >= WORDWD) err = 1'b1;
            if (wc >= 0 && wa[wc] >= WORDWD) err = 1'b1;
            if (exp_write) ref_mem[wa[wc]] = wd[wc];
            for (int i = 0; i < NREQ; i++) begin
                if (rg && rvp[i] && i != rc) begin
                    rwait[i]++;
                    total++;
                    if (rwait[i] >= NREQ) begin bad++; $display("FAIL rnd_rd_starve client=%0d got=%0d want<%0d", i, rwait[i], NREQ); end
                end
                if (wc >= 0 && wvp[i] && i != wc) begin
                    wwait[i]++;
                    total++;
                    if (wwait[i] >= NREQ) begin bad++; $display("FAIL rnd_wr_starve client=%0d got=%0d want<%0d", i, wwait[i], NREQ); end
                end
            end
            if (rg) begin rvp[rc] = 1'b0; rwait[rc] = 0; rptr = (rc + 1) % NREQ; end
            if (wc >= 0) begin wvp[wc] = 1'b0; wwait[wc] = 0; wptr = (wc + 1) % NREQ; end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AWD); i++) rf_mem[i] = '0;
        bus.i_rd_valid = '0;
        bus.i_wr_valid = '0;
        bus.i_rd_addr  = '0;
        bus.i_wr_addr  = '0;
        bus.i_wr_data  = '0;
        bus.i_rf_rdata = '0;
        test_reset();
        test_rr_reads();
        test_basic_rw();
        test_collision();
        test_addr_err();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=no completion want=finish before 500000ns");
        $fatal(1, "timeout");
    end
endmodule
